input_buffer_fifo: RTL and testbench

//  Parametrised keyboard input stage for the basic computer. Replaces the single input

---
 rtl/input_buffer_fifo.sv | 133 +++++++++++++
 tb/tb_input_buffer_fifo.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/input_buffer_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : input_buffer_fifo
//  Description : Keyboard input stage. The asynchronous input_arrived_flag
//                strobe is synchronised and rising-edge detected; each
//                detected edge pushes keyboard_input into a DEPTH-entry
//                first-word-fall-through FIFO. The CPU sees the head word on
//                input_data together with an FGI-style ready flag and pops
//                with a one-cycle read_ack pulse (issued by INP).
//  Ports       :
//    clk                 in   1         system clock, posedge
//    rst_n               in   1         asynchronous active-low reset
//    keyboard_input      in   DATA_W    character, stable while flag high
//    input_arrived_flag  in   1         async strobe, rising edge = new char
//    read_ack            in   1         pop head word (one pulse per word)
//    clear_overflow      in   1         synchronous clear of overflow sticky
//    input_data          out  DATA_W    head word when not empty, else 0
//    fgi                 out  1         1 when at least one word is stored
//    full                out  1         1 when DEPTH words are stored
//    overflow            out  1         sticky: a character was dropped
//    count               out  ADDR_W+1  stored words, 0..DEPTH
//  Parameters  : DATA_W (word width), DEPTH (power of two, >= 2)
//  Revision    : 1.0  initial release
// ============================================================================
module input_buffer_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [DATA_W-1:0]         keyboard_input,
    input  logic                      input_arrived_flag,
    input  logic                      read_ack,
    input  logic                      clear_overflow,
    output logic [DATA_W-1:0]         input_data,
    output logic                      fgi,
    output logic                      full,
    output logic                      overflow,
    output logic [$clog2(DEPTH):0]    count
);

    // Pointer width is derived from DEPTH and never overridden.
    localparam int ADDR_W = $clog2(DEPTH);
    localparam logic [ADDR_W:0] c_full_count = (ADDR_W+1)'(DEPTH);

    // Synchroniser / edge detector. r_s1 and r_s2 form the two-flop
    // metastability guard; r_s3 holds the previous synchronised value.
    logic r_s1;
    logic r_s2;
    logic r_s3;

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [ADDR_W-1:0] r_wp;
    logic [ADDR_W-1:0] r_rp;
    logic [ADDR_W:0]   r_count;
    logic              r_overflow;

    logic w_wr_evt;
    logic w_empty;
    logic w_full;
    logic w_do_rd;
    logic w_do_wr;
    logic w_drop;

    assign w_wr_evt = r_s2 & ~r_s3;
    assign w_empty  = (r_count == '0);
    assign w_full   = (r_count == c_full_count);

    // A read on empty is ignored. A write while full is still accepted when
    // a read frees a slot in the same cycle, so no word is lost in that case.
    assign w_do_rd  = read_ack & ~w_empty;
    assign w_do_wr  = w_wr_evt & (~w_full | w_do_rd);
    assign w_drop   = w_wr_evt & w_full & ~w_do_rd;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
            r_s3 <= 1'b0;
        end else begin
            r_s1 <= input_arrived_flag;
            r_s2 <= r_s1;
            r_s3 <= r_s2;
        end
    end

    // Pointers wrap through natural ADDR_W rollover (DEPTH is a power of two).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wp    <= '0;
            r_rp    <= '0;
            r_count <= '0;
        end else begin
            if (w_do_wr) begin
                r_wp <= r_wp + 1'b1;
            end
            if (w_do_rd) begin
                r_rp <= r_rp + 1'b1;
            end
            case ({w_do_wr, w_do_rd})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Set has priority over clear so a drop in the clearing cycle is not lost.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_overflow <= 1'b0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
        end else if (clear_overflow) begin
            r_overflow <= 1'b0;
        end
    end

    // Storage needs no reset: a slot is only visible once count covers it.
    always_ff @(posedge clk) begin
        if (w_do_wr) begin
            r_mem[r_wp] <= keyboard_input;
        end
    end

    assign input_data = w_empty ? '0 : r_mem[r_rp];
    assign fgi        = ~w_empty;
    assign full       = w_full;
    assign overflow   = r_overflow;
    assign count      = r_count;

endmodule
`default_nettype wire

// File: tb/tb_input_buffer_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : tb_input_buffer_fifo
//  Description : Self-checking bench for input_buffer_fifo (DATA_W=8,
//                DEPTH=4). A queue of expected characters is the reference
//                model; stimulus pushes accepted characters into it and a
//                monitor pops and compares whenever the CPU side pops.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_input_buffer_fifo;

    localparam int DATA_W = 8;
    localparam int DEPTH  = 4;

    logic              clk;
    logic              rst_n;
    logic [DATA_W-1:0] keyboard_input;
    logic              input_arrived_flag;
    logic              read_ack;
    logic              clear_overflow;
    logic [DATA_W-1:0] input_data;
    logic              fgi;
    logic              full;
    logic              overflow;
    logic [2:0]        count;

    input_buffer_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .keyboard_input     (keyboard_input),
        .input_arrived_flag (input_arrived_flag),
        .read_ack           (read_ack),
        .clear_overflow     (clear_overflow),
        .input_data         (input_data),
        .fgi                (fgi),
        .full               (full),
        .overflow           (overflow),
        .count              (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: characters the FIFO should hold, oldest first.
    logic [DATA_W-1:0] exp_q[$];
    logic              exp_ovf;

    int n_cmp;
    int n_err;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model-side acceptance of a character whose write edge has passed.
    task automatic model_write(input logic [DATA_W-1:0] d);
        if (exp_q.size() < DEPTH) exp_q.push_back(d);
        else                      exp_ovf = 1'b1;
    endtask

    task automatic check_state(input string tag);
        logic [DATA_W-1:0] head;
        head = (exp_q.size() != 0) ? exp_q[0] : '0;
        chk({tag, ".count"},    32'(count),      32'(exp_q.size()));
        chk({tag, ".fgi"},      32'(fgi),        32'(exp_q.size() != 0));
        chk({tag, ".full"},     32'(full),       32'(exp_q.size() == DEPTH));
        chk({tag, ".overflow"}, 32'(overflow),   32'(exp_ovf));
        chk({tag, ".data"},     32'(input_data), 32'(head));
    endtask

    // Monitor: read_ack is driven just after a posedge, so at the following
    // negedge the pop is pending and the head word must be the oldest model entry.
    always @(negedge clk) begin
        if (rst_n && read_ack) begin
            if (exp_q.size() != 0) begin
                chk("pop.fgi",  32'(fgi),        32'd1);
                chk("pop.data", 32'(input_data), 32'(exp_q.pop_front()));
            end else begin
                chk("pop_empty.fgi",  32'(fgi),        32'd0);
                chk("pop_empty.data", 32'(input_data), 32'd0);
            end
        end
    end

    // Full strobe: flag high for 'hold' sampled edges, then enough idle
    // cycles for the synchronised write to land before the model is updated.
    task automatic send_char(input logic [DATA_W-1:0] d, input int hold);
        @(posedge clk); #1;
        keyboard_input     = d;
        input_arrived_flag = 1'b1;
        repeat (hold) @(posedge clk);
        #1 input_arrived_flag = 1'b0;
        repeat (3) @(posedge clk);
        model_write(d);
    endtask

    task automatic pop();
        @(posedge clk); #1 read_ack = 1'b1;
        @(posedge clk); #1 read_ack = 1'b0;
    endtask

    task automatic do_clear();
        @(posedge clk); #1 clear_overflow = 1'b1;
        @(posedge clk); #1 clear_overflow = 1'b0;
        exp_ovf = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_cmp = 0;
        n_err = 0;
        exp_ovf = 1'b0;
        rst_n = 1'b0;
        keyboard_input = '0;
        input_arrived_flag = 1'b0;
        read_ack = 1'b0;
        clear_overflow = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_state("reset");
        rst_n = 1'b1;

        // Single character with latency check: sampled at edge N, visible after N+2.
        @(posedge clk); #1;
        keyboard_input = 8'h41;
        input_arrived_flag = 1'b1;
        @(posedge clk);             // edge N
        @(negedge clk);
        chk("lat.N.fgi", 32'(fgi), 32'd0);
        @(posedge clk); #1;         // edge N+1
        input_arrived_flag = 1'b0;
        @(negedge clk);
        chk("lat.N1.fgi", 32'(fgi), 32'd0);
        @(posedge clk);             // edge N+2
        model_write(8'h41);
        @(negedge clk);
        chk("lat.N2.data", 32'(input_data), 32'h41);
        check_state("one_char");
        pop();
        @(negedge clk);
        check_state("one_char_popped");

        // Five characters into a four-deep FIFO: the fifth is dropped.
        for (int i = 0; i < 5; i++) send_char(8'(8'h10 + i), 1);
        @(negedge clk);
        check_state("overfill");
        for (int i = 0; i < 4; i++) pop();
        @(negedge clk);
        check_state("overfill_drained");

        // Empty read leaves everything alone; then clear the sticky flag.
        pop();
        @(negedge clk);
        check_state("empty_read");
        do_clear();
        @(negedge clk);
        check_state("cleared");

        // Full FIFO with a write and a read landing on the same edge.
        for (int i = 0; i < 4; i++) send_char(8'(8'h20 + i), 2);
        @(posedge clk); #1;
        keyboard_input = 8'h99;
        input_arrived_flag = 1'b1;
        @(posedge clk); #1;         // edge N
        @(posedge clk); #1;         // edge N+1
        input_arrived_flag = 1'b0;
        read_ack = 1'b1;
        @(posedge clk); #1;         // edge N+2: write and pop together
        read_ack = 1'b0;
        model_write(8'h99);
        @(negedge clk);
        check_state("full_rw");

        // Drop coinciding with clear_overflow: the set wins.
        @(posedge clk); #1;
        keyboard_input = 8'hA5;
        input_arrived_flag = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        input_arrived_flag = 1'b0;
        clear_overflow = 1'b1;
        @(posedge clk); #1;
        clear_overflow = 1'b0;
        model_write(8'hA5);
        @(negedge clk);
        check_state("set_wins");
        while (exp_q.size() != 0) pop();
        do_clear();
        @(negedge clk);
        check_state("drained2");

        // Flag held for 20 cycles gives exactly one write.
        send_char(8'h55, 20);
        @(negedge clk);
        check_state("long_flag");
        pop();

        // Asynchronous reset mid-stream with overflow set.
        for (int i = 0; i < 5; i++) send_char(8'(8'h30 + i), 1);
        pop();
        pop();
        @(negedge clk); #2;
        rst_n = 1'b0;
        #1;
        exp_q.delete();
        exp_ovf = 1'b0;
        check_state("async_reset");
        // Flag rises while in reset and stays high across release: one capture.
        keyboard_input = 8'h77;
        input_arrived_flag = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (4) @(posedge clk);
        #1 input_arrived_flag = 1'b0;
        repeat (3) @(posedge clk);
        model_write(8'h77);
        @(negedge clk);
        check_state("post_reset");
        send_char(8'h78, 1);
        pop();
        pop();
        @(negedge clk);
        check_state("post_reset_drained");

        // Randomised mix of characters, pops and overflow clears.
        for (int i = 0; i < 80; i++) begin
            int r;
            r = $urandom_range(0, 9);
            if (r < 5)      send_char(8'($urandom), $urandom_range(1, 5));
            else if (r < 8) pop();
            else if (r < 9) do_clear();
            else            repeat ($urandom_range(1, 3)) @(posedge clk);
            @(negedge clk);
            check_state("rand");
        end
        while (exp_q.size() != 0) pop();
        @(negedge clk);
        check_state("final");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
